// File: rtl/plot_sink.sv
// Pixel-plot sink: clips off-screen requests, queues on-screen ones in a FIFO
// and drains them as linear framebuffer writes. Optional PLOT_DEDUP_EN drops repeats.
module plot_sink #(
    parameter int DEPTH = 16,
    parameter int XMAX  = 160,
    parameter int YMAX  = 120
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_x,
    input  logic [6:0]                 in_y,
    input  logic [2:0]                 in_colour,
    input  logic                       mem_busy,
    output logic                       mem_we,
    output logic [14:0]                mem_addr,
    output logic [2:0]                 mem_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 drop_count
);
    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);
    localparam logic [7:0]     XLIM = 8'(XMAX);
    localparam logic [6:0]     YLIM = 7'(YMAX);

    logic [17:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;
    logic [7:0]    r_drop;
    logic          r_we;
    logic [14:0]   r_addr;
    logic [2:0]    r_data;

    logic          w_accept;
    logic          w_onscreen;
    logic          w_dup;
    logic          w_push;
    logic          w_pop;
    logic [17:0]   w_entry;
    logic [17:0]   w_head;
    logic [7:0]    w_hx;
    logic [6:0]    w_hy;
    logic [2:0]    w_hc;
    logic [14:0]   w_addr;

    assign in_ready   = (r_level != FULL);
    assign w_accept   = in_valid && in_ready;
    assign w_onscreen = (in_x < XLIM) && (in_y < YLIM);
    assign w_entry    = {in_x, in_y, in_colour};
    assign w_push     = w_accept && w_onscreen && !w_dup;
    assign w_pop      = (r_level != '0) && !mem_busy;

`ifdef PLOT_DEDUP_EN
    logic [17:0] r_last;
    logic        r_last_vld;

    // Repeats are still accepted (and not counted as drops), just never queued.
    assign w_dup = r_last_vld && (r_last == w_entry);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_push) begin
            r_last     <= w_entry;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_head = r_mem[r_rd];
    assign w_hx   = w_head[17:10];
    assign w_hy   = w_head[9:3];
    assign w_hc   = w_head[2:0];
    // y*160 + x as two shifts; fits 15 bits for every on-screen pixel.
    assign w_addr = ({8'b0, w_hy} << 7) + ({8'b0, w_hy} << 5) + {7'b0, w_hx};

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= w_entry;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_drop  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_accept && !w_onscreen && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
            r_we <= w_pop;
            if (w_pop) begin
                r_addr <= w_addr;
                r_data <= w_hc;
            end
        end
    end

    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_data   = r_data;
    assign fifo_level = r_level;
    assign drop_count = r_drop;
endmodule
